// File: rtl/sub_word_mau_pkg.sv
// Shared encodings and helpers for the sub-word memory access unit:
// access sizes, operation type, controller states and alignment helpers.
package sub_word_mau_pkg;

  // Access size as carried on req_size.
  typedef enum logic [1:0] {
    MAU_SIZE_B = 2'b00,
    MAU_SIZE_H = 2'b01,
    MAU_SIZE_W = 2'b10,
    MAU_SIZE_D = 2'b11
  } mau_size_e;

  // Operation type as carried on req_we.
  typedef enum logic {
    MAU_OP_LOAD  = 1'b0,
    MAU_OP_STORE = 1'b1
  } mau_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    MAU_ST_IDLE = 2'b00,
    MAU_ST_RD   = 2'b01,
    MAU_ST_WR   = 2'b10,
    MAU_ST_RESP = 2'b11
  } mau_state_e;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] mau_size_bytes(input logic [1:0] size);
    logic [3:0] bytes;
    case (size)
      MAU_SIZE_B: bytes = 4'd1;
      MAU_SIZE_H: bytes = 4'd2;
      MAU_SIZE_W: bytes = 4'd4;
      default:    bytes = 4'd8;
    endcase
    return bytes;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic mau_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] low_mask;
    low_mask = mau_size_bytes(size) - 4'd1;
    return |({1'b0, off} & low_mask);
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering between a full memory word and a sub-word
// access: extracts and extends load data, and merges store data into the
// old word for read-modify-write.
module byte_lane_align
  import sub_word_mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [OFF_W+2:0]  shamt_s;
  logic [6:0]        nbits_s;
  logic [DATA_W-1:0] size_mask_s;
  logic [DATA_W-1:0] msb_mask_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] lane_mask_s;
  logic              sign_s;

  // Turn byte offset and size into a bit shift and a right-justified field mask.
  always_comb begin
    shamt_s     = {off_i, 3'b000};
    nbits_s     = {mau_size_bytes(size_i), 3'b000};
    // A shift by the full word width yields zero, so a full-width size gives all ones.
    size_mask_s = ~({DATA_W{1'b1}} << nbits_s);
    msb_mask_s  = size_mask_s & ~(size_mask_s >> 1'b1);
  end

  // Load path: bring the addressed lane down to bit 0, then sign- or zero-fill.
  always_comb begin
    shifted_s = rdata_i >> shamt_s;
    sign_s    = |(shifted_s & msb_mask_s);
    if (!uns_i && sign_s) begin
      load_o = (shifted_s & size_mask_s) | ~size_mask_s;
    end else begin
      load_o = shifted_s & size_mask_s;
    end
  end

  // Store path: replace only the addressed lane of the old word.
  always_comb begin
    lane_mask_s = size_mask_s << shamt_s;
    merge_o     = (rdata_i & ~lane_mask_s) | ((wdata_i << shamt_s) & lane_mask_s);
  end

endmodule

// File: rtl/sub_word_mau.sv
// Memory access unit between the CPU MEM stage and a word-wide data memory
// without byte enables. Handles byte/half/word/double loads with extension,
// sub-word stores by read-modify-write, and rejects misaligned accesses
// without touching memory.
module sub_word_mau
  import sub_word_mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         OFF_W      = $clog2(DATA_W / 8);
  localparam logic [3:0] WORD_BYTES = 4'(DATA_W / 8);
  localparam logic       HAS_DOUBLE = (DATA_W == 64);

  mau_state_e        state_q, state_d;
  mau_op_e           op_q, op_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              illegal_s;
  logic              misalign_s;
  logic              full_s;
  logic [DATA_W-1:0] load_s;
  logic [DATA_W-1:0] merge_s;

  byte_lane_align #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_align (
    .rdata_i(mem_rdata),
    .off_i  (addr_q[OFF_W-1:0]),
    .size_i (size_q),
    .uns_i  (uns_q),
    .wdata_i(wdata_q),
    .load_o (load_s),
    .merge_o(merge_s)
  );

  // Classify the incoming request: illegal size, misalignment, full-width store.
  always_comb begin
    illegal_s  = (req_size == MAU_SIZE_D) && !HAS_DOUBLE;
    misalign_s = mau_misaligned(3'(req_addr[OFF_W-1:0]), req_size);
    full_s     = (mau_size_bytes(req_size) == WORD_BYTES);
  end

  // Next-state and latched-field update for the access controller.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      MAU_ST_IDLE: begin
        if (req_valid) begin
          op_d    = mau_op_e'(req_we);
          size_d  = req_size;
          uns_d   = req_uns;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = {DATA_W{1'b0}};
          err_d   = illegal_s | misalign_s;
          if (illegal_s || misalign_s) begin
            state_d = MAU_ST_RESP;
          end else if (!req_we) begin
            state_d = MAU_ST_RD;
          end else if (full_s) begin
            state_d = MAU_ST_WR;
          end else begin
            // Sub-word store: fetch the old word first.
            state_d = MAU_ST_RD;
          end
        end else begin
          state_d = MAU_ST_IDLE;
        end
      end
      MAU_ST_RD: begin
        if (mem_ack) begin
          if (op_q == MAU_OP_STORE) begin
            wdata_d = merge_s;
            state_d = MAU_ST_WR;
          end else begin
            rdata_d = load_s;
            state_d = MAU_ST_RESP;
          end
        end else begin
          state_d = MAU_ST_RD;
        end
      end
      MAU_ST_WR: begin
        if (mem_ack) begin
          state_d = MAU_ST_RESP;
        end else begin
          state_d = MAU_ST_WR;
        end
      end
      MAU_ST_RESP: begin
        state_d = MAU_ST_IDLE;
      end
      default: begin
        state_d = MAU_ST_IDLE;
      end
    endcase
  end

  // State and latched request fields; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MAU_ST_IDLE;
      op_q    <= MAU_OP_LOAD;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Output decode from registered state; all buses read zero outside their phase.
  always_comb begin
    req_ready  = (state_q == MAU_ST_IDLE);
    resp_valid = (state_q == MAU_ST_RESP);
    mem_req    = (state_q == MAU_ST_RD) || (state_q == MAU_ST_WR);
    mem_we     = (state_q == MAU_ST_WR);
    resp_err   = 1'b0;
    resp_rdata = {DATA_W{1'b0}};
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    if (resp_valid) begin
      resp_err   = err_q;
      resp_rdata = rdata_q;
    end else begin
      resp_err   = 1'b0;
      resp_rdata = {DATA_W{1'b0}};
    end
    if (mem_req) begin
      mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end else begin
      mem_addr = {ADDR_W{1'b0}};
    end
    if (mem_we) begin
      mem_wdata = wdata_q;
    end else begin
      mem_wdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_sub_word_mau.sv
// Self-checking bench for sub_word_mau: a 32-bit and a 64-bit instance share
// one request driver and one behavioural memory, selected by sel64.
// Expected responses and memory operations are queued when a request is
// driven and compared when the DUT produces them.
module tb_sub_word_mau;
  import sub_word_mau_pkg::*;

  logic clk;
  logic rst;
  logic sel64;
  logic req_valid, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        r32_ready, r32_valid, r32_err, m32_req, m32_we;
  logic [31:0] r32_rdata, m32_addr, m32_wdata;
  logic        r64_ready, r64_valid, r64_err, m64_req, m64_we;
  logic [63:0] r64_rdata, m64_wdata;
  logic [31:0] m64_addr;
  logic        rv32, rv64;

  logic        rdy, rvalid, rerr, mreq, mwe;
  logic [63:0] rrdata, mwdata;
  logic [31:0] maddr;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  string cur = "reset";

  typedef struct { logic err; logic [63:0] rdata; int lat; int acc; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [63:0] data; } op_t;
  resp_t resp_q[$];
  op_t   op_q[$];

  logic [63:0] mem [logic [31:0]];
  int          ack_wait;
  logic        stray_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rv32 = req_valid & ~sel64;
  assign rv64 = req_valid & sel64;

  sub_word_mau #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(r32_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(r32_valid), .resp_err(r32_err), .resp_rdata(r32_rdata),
    .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr), .mem_wdata(m32_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0])
  );

  sub_word_mau #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(r64_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r64_valid), .resp_err(r64_err), .resp_rdata(r64_rdata),
    .mem_req(m64_req), .mem_we(m64_we), .mem_addr(m64_addr), .mem_wdata(m64_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // View of whichever instance is currently under test.
  always_comb begin
    if (sel64) begin
      rdy = r64_ready; rvalid = r64_valid; rerr = r64_err; rrdata = r64_rdata;
      mreq = m64_req; mwe = m64_we; maddr = m64_addr; mwdata = m64_wdata;
    end else begin
      rdy = r32_ready; rvalid = r32_valid; rerr = r32_err; rrdata = {32'h0, r32_rdata};
      mreq = m32_req; mwe = m32_we; maddr = m32_addr; mwdata = {32'h0, m32_wdata};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (%s): got 0x%0h expected 0x%0h", tag, cur, got, exp);
    end
  endtask

  task automatic exp_op(input logic we, input logic [31:0] addr, input logic [63:0] data);
    op_t o;
    o.we = we; o.addr = addr; o.data = data;
    op_q.push_back(o);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic track,
                       input logic err, input logic [63:0] rdata, input int lat);
    resp_t r;
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 64'(n < 50), 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (track) begin
      r.err = err; r.rdata = rdata; r.lat = lat; r.acc = cyc;
      resp_q.push_back(r);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((resp_q.size() != 0 || op_q.size() != 0 || !rdy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(n < 100), 64'd1);
  endtask

  // Behavioural memory: acks after ack_wait idle cycles, checks each op and bus stability.
  always @(negedge clk) begin : responder
    op_t         e;
    int          wait_cnt;
    logic        hold_v;
    logic [31:0] hold_addr;
    logic        hold_we;
    logic [63:0] hold_wdata;
    if (rst) begin
      mem_ack = 1'b0; mem_rdata = 64'd0; wait_cnt = 0; hold_v = 1'b0;
    end else if (mreq) begin
      if (hold_v) begin
        chk("hold_addr", 64'(maddr), 64'(hold_addr));
        chk("hold_we", 64'(mwe), 64'(hold_we));
        chk("hold_wdata", mwdata, hold_wdata);
      end else begin
        hold_v = 1'b1; hold_addr = maddr; hold_we = mwe; hold_wdata = mwdata;
      end
      if (wait_cnt >= ack_wait) begin
        mem_ack = 1'b1; wait_cnt = 0; hold_v = 1'b0;
        mem_rdata = mem.exists(maddr) ? mem[maddr] : 64'd0;
        chk("op_expected", 64'(op_q.size() != 0), 64'd1);
        if (op_q.size() != 0) begin
          e = op_q.pop_front();
          chk("op_we", 64'(mwe), 64'(e.we));
          chk("op_addr", 64'(maddr), 64'(e.addr));
          if (e.we) chk("op_wdata", mwdata, e.data);
        end
        if (mwe) mem[maddr] = mwdata;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = stray_ack; wait_cnt = 0; hold_v = 1'b0;
    end
  end

  // Response scoreboard: every resp_valid must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    resp_t r;
    if (!rst && rvalid) begin
      chk("resp_expected", 64'(resp_q.size() != 0), 64'd1);
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        chk("resp_err", 64'(rerr), 64'(r.err));
        chk("resp_rdata", rrdata, r.rdata);
        chk("resp_latency", 64'(cyc - r.acc + 1), 64'(r.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_uns = 1'b0;
    req_size = 2'b00; req_addr = 32'd0; req_wdata = 64'd0;
    ack_wait = 0; stray_ack = 1'b0;
    mem[32'h100]  = 64'h80FF1234;
    mem[32'h1000] = 64'h11223344;
    repeat (2) @(negedge clk);
    chk("rst_ctrl32", 64'({r32_ready, r32_valid, r32_err, m32_req, m32_we}), 64'h10);
    chk("rst_bus32", 64'({r32_rdata, m32_addr}) | 64'(m32_wdata), 64'd0);
    chk("rst_ctrl64", 64'({r64_ready, r64_valid, r64_err, m64_req, m64_we}), 64'h10);
    chk("rst_bus64", r64_rdata | m64_wdata | 64'(m64_addr), 64'd0);
    rst = 1'b0;

    // 32-bit loads with sign/zero extension
    cur = "lb_signed";
    exp_op(1'b0, 32'h100, 64'd0);
    issue(1'b0, MAU_SIZE_B, 1'b0, 32'h103, 64'd0, 1'b1, 1'b0, 64'hFFFFFF80, 2); wait_done();
    cur = "lbu";
    exp_op(1'b0, 32'h100, 64'd0);
    issue(1'b0, MAU_SIZE_B, 1'b1, 32'h103, 64'd0, 1'b1, 1'b0, 64'h80, 2); wait_done();
    cur = "lh_signed";
    exp_op(1'b0, 32'h100, 64'd0);
    issue(1'b0, MAU_SIZE_H, 1'b0, 32'h102, 64'd0, 1'b1, 1'b0, 64'hFFFF80FF, 2); wait_done();
    cur = "lhu";
    exp_op(1'b0, 32'h100, 64'd0);
    issue(1'b0, MAU_SIZE_H, 1'b1, 32'h102, 64'd0, 1'b1, 1'b0, 64'h80FF, 2); wait_done();
    cur = "lw";
    exp_op(1'b0, 32'h100, 64'd0);
    issue(1'b0, MAU_SIZE_W, 1'b0, 32'h100, 64'd0, 1'b1, 1'b0, 64'h80FF1234, 2); wait_done();

    // sub-word store by read-modify-write
    cur = "sb_rmw";
    exp_op(1'b0, 32'h1000, 64'd0);
    exp_op(1'b1, 32'h1000, 64'h1122AB44);
    issue(1'b1, MAU_SIZE_B, 1'b0, 32'h1001, 64'hAB, 1'b1, 1'b0, 64'd0, 3); wait_done();
    cur = "lh_after_sb";
    exp_op(1'b0, 32'h1000, 64'd0);
    issue(1'b0, MAU_SIZE_H, 1'b0, 32'h1002, 64'd0, 1'b1, 1'b0, 64'h1122, 2); wait_done();

    // rejected accesses never reach memory
    cur = "lh_misaligned";
    issue(1'b0, MAU_SIZE_H, 1'b0, 32'h1001, 64'd0, 1'b1, 1'b1, 64'd0, 1); wait_done();
    cur = "double_on_32";
    issue(1'b0, MAU_SIZE_D, 1'b0, 32'h0, 64'd0, 1'b1, 1'b1, 64'd0, 1); wait_done();

    // full store with a slow memory, then a sub-word store with wait states
    cur = "sw_wait3";
    ack_wait = 3;
    exp_op(1'b1, 32'h2000, 64'hCAFEF00D);
    issue(1'b1, MAU_SIZE_W, 1'b0, 32'h2000, 64'hCAFEF00D, 1'b1, 1'b0, 64'd0, 5); wait_done();
    cur = "sh_wait1";
    ack_wait = 1;
    exp_op(1'b0, 32'h2000, 64'd0);
    exp_op(1'b1, 32'h2000, 64'h5566F00D);
    issue(1'b1, MAU_SIZE_H, 1'b0, 32'h2002, 64'h5566, 1'b1, 1'b0, 64'd0, 5); wait_done();

    // reset while a write is waiting for its ack
    cur = "rst_in_wr";
    ack_wait = 20;
    issue(1'b1, MAU_SIZE_W, 1'b0, 32'h3000, 64'h0BAD0BAD, 1'b0, 1'b0, 64'd0, 0);
    n = 0;
    while (!mwe && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wr_reached", 64'(mwe), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_drops_req", 64'(mreq), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; ack_wait = 0;
    #1 chk("ready_after_rst", 64'(rdy), 64'd1);
    cur = "lw_after_rst";
    exp_op(1'b0, 32'h2000, 64'd0);
    issue(1'b0, MAU_SIZE_W, 1'b0, 32'h2000, 64'd0, 1'b1, 1'b0, 64'h5566F00D, 2); wait_done();
    cur = "aborted_not_written";
    exp_op(1'b0, 32'h3000, 64'd0);
    issue(1'b0, MAU_SIZE_W, 1'b0, 32'h3000, 64'd0, 1'b1, 1'b0, 64'd0, 2); wait_done();

    // ack while no request is outstanding
    cur = "stray_ack";
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle", 64'({rdy, mreq, rvalid}), 64'h4);
    end
    stray_ack = 1'b0;
    @(negedge clk);

    // 64-bit instance
    sel64 = 1'b1;
    mem[32'h8] = 64'h0123456789ABCDEF;
    cur = "ld64";
    exp_op(1'b0, 32'h8, 64'd0);
    issue(1'b0, MAU_SIZE_D, 1'b0, 32'h8, 64'd0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 2); wait_done();
    cur = "lw64_upper";
    exp_op(1'b0, 32'h8, 64'd0);
    issue(1'b0, MAU_SIZE_W, 1'b0, 32'hC, 64'd0, 1'b1, 1'b0, 64'h01234567, 2); wait_done();
    cur = "lw64_signed";
    exp_op(1'b0, 32'h8, 64'd0);
    issue(1'b0, MAU_SIZE_W, 1'b0, 32'h8, 64'd0, 1'b1, 1'b0, 64'hFFFFFFFF89ABCDEF, 2); wait_done();
    cur = "lb64_top";
    exp_op(1'b0, 32'h8, 64'd0);
    issue(1'b0, MAU_SIZE_B, 1'b0, 32'hF, 64'd0, 1'b1, 1'b0, 64'h01, 2); wait_done();
    cur = "sh64_rmw";
    exp_op(1'b0, 32'h0, 64'd0);
    exp_op(1'b1, 32'h0, 64'hBEEF000000000000);
    issue(1'b1, MAU_SIZE_H, 1'b0, 32'h6, 64'hBEEF, 1'b1, 1'b0, 64'd0, 3); wait_done();
    cur = "lh64_signed";
    exp_op(1'b0, 32'h0, 64'd0);
    issue(1'b0, MAU_SIZE_H, 1'b0, 32'h6, 64'd0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFBEEF, 2); wait_done();
    cur = "ld64_misaligned";
    issue(1'b0, MAU_SIZE_D, 1'b0, 32'h4, 64'd0, 1'b1, 1'b1, 64'd0, 1); wait_done();
    cur = "sd64_full";
    exp_op(1'b1, 32'h10, 64'h1122334455667788);
    issue(1'b1, MAU_SIZE_D, 1'b0, 32'h10, 64'h1122334455667788, 1'b1, 1'b0, 64'd0, 2); wait_done();

    cur = "end";
    chk("ops_drained", 64'(op_q.size()), 64'd0);
    chk("resps_drained", 64'(resp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
